// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: definitions shared by the K&S datapath and control unit.
//   - decoded_instruction_type: instruction classes produced by the IR decoder
//   - opcode constants (IR[15:8]), ALU operation codes, IR field bit positions
//   - decode_opcode(): maps an opcode byte to its instruction class
package k_and_s_pkg;

    localparam int KS_DATA_W = 16;
    localparam int KS_ADDR_W = 5;

    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE,
        I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
        I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;

    // Opcodes, IR[15:8]
    localparam logic [7:0] OPC_NOP    = 8'h00;
    localparam logic [7:0] OPC_BRANCH = 8'h01;
    localparam logic [7:0] OPC_BZERO  = 8'h02;
    localparam logic [7:0] OPC_BNZERO = 8'h03;
    localparam logic [7:0] OPC_BNEG   = 8'h04;
    localparam logic [7:0] OPC_BNNEG  = 8'h05;
    localparam logic [7:0] OPC_BOV    = 8'h06;
    localparam logic [7:0] OPC_BNOV   = 8'h07;
    localparam logic [7:0] OPC_LOAD   = 8'h81;
    localparam logic [7:0] OPC_STORE  = 8'h82;
    localparam logic [7:0] OPC_MOVE   = 8'h91;
    localparam logic [7:0] OPC_ADD    = 8'hA1;
    localparam logic [7:0] OPC_SUB    = 8'hA2;
    localparam logic [7:0] OPC_AND    = 8'hA3;
    localparam logic [7:0] OPC_OR     = 8'hA4;
    localparam logic [7:0] OPC_HALT   = 8'hFF;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // IR field bit positions
    localparam int IR_OPC_HI      = 15;
    localparam int IR_OPC_LO      = 8;
    localparam int IR_LS_REG_HI   = 6;   // LOAD dst / STORE src
    localparam int IR_LS_REG_LO   = 5;
    localparam int IR_ALU_DST_HI  = 5;
    localparam int IR_ALU_DST_LO  = 4;
    localparam int IR_OPA_HI      = 3;   // also MOVE dst
    localparam int IR_OPA_LO      = 2;
    localparam int IR_OPB_HI      = 1;   // also MOVE src
    localparam int IR_OPB_LO      = 0;

    function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
        case (opc)
            OPC_BRANCH: return I_BRANCH;
            OPC_BZERO:  return I_BZERO;
            OPC_BNZERO: return I_BNZERO;
            OPC_BNEG:   return I_BNEG;
            OPC_BNNEG:  return I_BNNEG;
            OPC_BOV:    return I_BOV;
            OPC_BNOV:   return I_BNOV;
            OPC_LOAD:   return I_LOAD;
            OPC_STORE:  return I_STORE;
            OPC_MOVE:   return I_MOVE;
            OPC_ADD:    return I_ADD;
            OPC_SUB:    return I_SUB;
            OPC_AND:    return I_AND;
            OPC_OR:     return I_OR;
            OPC_HALT:   return I_HALT;
            default:    return I_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ks_datapath_if.sv
// ks_datapath_if: control-unit strobes, decode/flag feedback and RAM bus of
// the K&S datapath.
//   slave  : the datapath (takes strobes and data_in, drives decode, flags,
//            ram_addr, data_out)
//   master : control unit + RAM side
interface ks_datapath_if #(
    parameter int DATA_W = k_and_s_pkg::KS_DATA_W,
    parameter int ADDR_W = k_and_s_pkg::KS_ADDR_W
);
    import k_and_s_pkg::*;

    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    flags_reg_enable;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       data_out;
    logic [DATA_W-1:0]       data_in;

    modport slave (
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
               c_sel, operation, flags_reg_enable, data_in,
        output decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out
    );

    modport master (
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
               c_sel, operation, flags_reg_enable, data_in,
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out
    );
endinterface

// File: rtl/ks_alu.sv
// ks_alu: combinational ALU of the K&S datapath.
//   a_i, b_i       : operands
//   operation_i    : 00 add, 01 sub, 10 and, 11 or
//   result_o       : DATA_W-bit result (carry dropped)
//   zero_o, neg_o  : derived from result_o
//   unsigned_ov_o  : carry-out (add) / borrow (sub) / 0 (logic ops)
//   signed_ov_o    : two's-complement overflow (add/sub) / 0 (logic ops)
module ks_alu
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = KS_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        operation_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              neg_o,
    output logic              unsigned_ov_o,
    output logic              signed_ov_o
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] wide;

    always_comb begin
        wide          = '0;
        result_o      = '0;
        unsigned_ov_o = 1'b0;
        signed_ov_o   = 1'b0;
        case (operation_i)
            ALU_ADD: begin
                wide          = {1'b0, a_i} + {1'b0, b_i};
                result_o      = wide[MSB:0];
                unsigned_ov_o = wide[DATA_W];
                // Same-sign operands producing a result of the other sign
                signed_ov_o   = (a_i[MSB] == b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                // The extra bit of a zero-extended subtraction is the borrow (a < b)
                wide          = {1'b0, a_i} - {1'b0, b_i};
                result_o      = wide[MSB:0];
                unsigned_ov_o = wide[DATA_W];
                signed_ov_o   = (a_i[MSB] != b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            end
            ALU_AND: result_o = a_i & b_i;
            default: result_o = a_i | b_i;
        endcase
    end

    assign zero_o = (result_o == '0);
    assign neg_o  = result_o[MSB];

endmodule

// File: rtl/ks_datapath.sv
// ks_datapath: datapath of the K&S multicycle processor.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ks_datapath_if slave - control strobes (branch, pc_enable,
//                ir_enable, write_reg_enable, addr_sel, c_sel, operation,
//                flags_reg_enable), decoded_instruction and flag outputs,
//                RAM bus (ram_addr, data_out, data_in)
// Holds PC, IR, a 4-entry register file and the flags register; every state
// change is gated by a control-unit strobe.
module ks_datapath
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = KS_DATA_W,
    parameter int ADDR_W = KS_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    ks_datapath_if.slave bus
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] regs_q [4];
    logic              zero_q, neg_q, uov_q, sov_q;

    decoded_instruction_type decoded;
    logic [1:0]        a_sel, b_sel, dst_sel;
    logic              dst_valid;
    logic [DATA_W-1:0] alu_result, wb_data;
    logic              alu_zero, alu_neg, alu_uov, alu_sov;
    logic              ir_unused;

    assign decoded   = decode_opcode(ir_q[IR_OPC_HI:IR_OPC_LO]);
    assign ir_unused = ir_q[7];

    // Operand / destination selection per instruction class. Only LOAD,
    // MOVE and the ALU classes own a destination register.
    always_comb begin
        a_sel     = ir_q[IR_OPA_HI:IR_OPA_LO];
        b_sel     = ir_q[IR_OPB_HI:IR_OPB_LO];
        dst_sel   = ir_q[IR_ALU_DST_HI:IR_ALU_DST_LO];
        dst_valid = 1'b0;
        case (decoded)
            I_LOAD: begin
                dst_sel   = ir_q[IR_LS_REG_HI:IR_LS_REG_LO];
                dst_valid = 1'b1;
            end
            I_MOVE: begin
                // Both operands read src so that OR passes it through
                a_sel     = ir_q[IR_OPB_HI:IR_OPB_LO];
                b_sel     = ir_q[IR_OPB_HI:IR_OPB_LO];
                dst_sel   = ir_q[IR_OPA_HI:IR_OPA_LO];
                dst_valid = 1'b1;
            end
            I_ADD, I_SUB, I_AND, I_OR: dst_valid = 1'b1;
            default: ;
        endcase
    end

    ks_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i          (regs_q[a_sel]),
        .b_i          (regs_q[b_sel]),
        .operation_i  (bus.operation),
        .result_o     (alu_result),
        .zero_o       (alu_zero),
        .neg_o        (alu_neg),
        .unsigned_ov_o(alu_uov),
        .signed_ov_o  (alu_sov)
    );

    assign wb_data = bus.c_sel ? bus.data_in : alu_result;

    // Branch target is taken from the IR value before any same-cycle IR load
    always_comb begin
        pc_d = pc_q;
        if (bus.pc_enable)
            pc_d = bus.branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (bus.ir_enable)
                ir_q <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                regs_q[i] <= '0;
        end else if (bus.write_reg_enable && dst_valid) begin
            regs_q[dst_sel] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uov_q  <= 1'b0;
            sov_q  <= 1'b0;
        end else if (bus.flags_reg_enable) begin
            zero_q <= alu_zero;
            neg_q  <= alu_neg;
            uov_q  <= alu_uov;
            sov_q  <= alu_sov;
        end
    end

    assign bus.decoded_instruction = decoded;
    assign bus.zero_op             = zero_q;
    assign bus.neg_op              = neg_q;
    assign bus.unsigned_overflow   = uov_q;
    assign bus.signed_overflow     = sov_q;
    assign bus.ram_addr            = bus.addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign bus.data_out            = regs_q[ir_q[IR_LS_REG_HI:IR_LS_REG_LO]];

endmodule

// File: doc/ks_datapath.md
Name: ks_datapath

Overview:
Datapath of the K&S multicycle processor. Holds the PC, the IR, a 4-entry register file, the ALU and the flags register. It decodes the IR into decoded_instruction for the control unit and drives the RAM address and write-data buses. Every register update happens only under control-unit strobes; the block has no FSM of its own.

Parameters:
DATA_W, 16, data, instruction and register width
ADDR_W, 5, RAM address / PC width (32 words)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
branch  in  1  PC load source select: 1 = IR address field, 0 = PC+1
pc_enable  in  1  PC update strobe
ir_enable  in  1  IR load strobe (IR <= data_in)
write_reg_enable  in  1  register-file write strobe
addr_sel  in  1  ram_addr select: 1 = IR address field, 0 = PC
c_sel  in  1  write-back source: 1 = data_in, 0 = ALU result
operation  in  2  ALU op: 00 add, 01 sub, 10 and, 11 or
flags_reg_enable  in  1  flags register load strobe
decoded_instruction  out  decoded_instruction_type  combinational decode of IR
zero_op  out  1  registered zero flag
neg_op  out  1  registered negative flag
unsigned_overflow  out  1  registered carry/borrow flag
signed_overflow  out  1  registered two's-complement overflow flag
ram_addr  out  ADDR_W  RAM address
data_out  out  DATA_W  RAM write data
data_in  in  DATA_W  RAM read data

Behaviour:
- Reset (async): PC, IR, R0-R3 and all four flags clear to 0.
- Reset consequences: decoded_instruction = I_NOP, ram_addr = 0, data_out = 0.
- Reset asserted mid-instruction clears state immediately. The block resumes from PC 0.
- Encoding, IR[15:8] opcode:
  - 0x00 NOP.
  - 0x01 BRANCH, 0x02 BZERO, 0x03 BNZERO, 0x04 BNEG, 0x05 BNNEG, 0x06 BOV, 0x07 BNOV. Address field is IR[4:0].
  - 0x81 LOAD: dst IR[6:5], addr IR[4:0].
  - 0x82 STORE: src IR[6:5], addr IR[4:0].
  - 0x91 MOVE: dst IR[3:2], src IR[1:0].
  - 0xA1 ADD, 0xA2 SUB, 0xA3 AND, 0xA4 OR: dst IR[5:4], opA IR[3:2], opB IR[1:0].
  - 0xFF HALT.
  - Any other opcode decodes to I_NOP.
- PC:
  - On pc_enable: branch ? IR[ADDR_W-1:0] : PC+1. PC+1 wraps 31 -> 0.
  - Without pc_enable the PC holds.
  - When pc_enable and ir_enable are asserted in the same cycle, the branch target comes from the old IR.
- ram_addr: combinational, addr_sel ? IR[ADDR_W-1:0] : PC.
- RAM read data is valid one cycle after the address is presented; the datapath samples data_in only on its strobes.
- data_out: combinational, always R[IR[6:5]].
- ALU:
  - Operands: A = R[opA], B = R[opB]. For MOVE, A = B = R[src], so op 11 passes src through.
  - Result is DATA_W bits; carry is discarded from the result.
  - Flags are computed from the result: zero = (result == 0); neg = result[MSB].
  - unsigned_overflow: carry-out for add; borrow (A < B, unsigned) for sub; 0 for and/or.
  - signed_overflow: standard two's-complement rule for add/sub; 0 for and/or.
- Flags register: all four flags load together on flags_reg_enable and otherwise hold.
- Register write on write_reg_enable: dst <= c_sel ? data_in : ALU result.
  - dst is chosen per decoded class (LOAD / MOVE / ALU).
  - For any other decoded instruction the write is suppressed.
  - Writes to the same register as the read operand update on the clock edge; reads see the old value in that cycle.
- Simultaneous flags_reg_enable and write_reg_enable are legal and independent.

Decomposition:
- k_and_s_pkg (shared with the control unit) holds:
  - decoded_instruction_type with I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT;
  - opcode constants;
  - ALU op constants;
  - IR field bit positions.
- Sub-module ks_alu: combinational; A, B and operation in; result plus four flag values out.
- Decoder, PC, IR, register file and flags register stay in ks_datapath.

Test Plan:
- Reset check: after rst_n deassert -> PC = 0, IR = 0, R0-R3 = 0, flags = 0, decoded_instruction = I_NOP, ram_addr = 0.
- LOAD, fetch:
  - data_in = 0x8123 with ir_enable + pc_enable -> IR = 0x8123, PC = 1, decoded = I_LOAD.
  - addr_sel = 1 -> ram_addr = 0x03.
- LOAD, write-back: data_in = 0xBEEF with c_sel + write_reg_enable -> R1 = 0xBEEF.
- ADD overflow: R1 = 0x7FFF, R2 = 0x0001, IR = 0xA136, op 00, write + flags -> R3 = 0x8000; neg = 1, signed_ov = 1, zero = 0, unsigned_ov = 0.
- SUB equal: R0 = R1 = 5, IR = 0xA201, op 01 -> R0 = 0, zero = 1, unsigned_ov = 0.
- SUB borrow: R0 = 3, R1 = 5 -> R0 = 0xFFFE, neg = 1, unsigned_ov = 1.
- Flags hold: with flags_reg_enable low, flags stay unchanged.
- Branch taken: IR = 0x0114, branch + pc_enable -> PC = 0x14.
- PC wrap: PC = 0x1F, pc_enable with branch = 0 -> PC = 0x00.
- STORE: R2 = 0x1234, IR = 0x8245, addr_sel = 1 -> ram_addr = 0x05, data_out = 0x1234.
- MOVE: R3 = 0x00AA, IR = 0x9107 (dst R1, src R3), op 11 + write_reg_enable -> R1 = 0x00AA.
- Suppressed write: IR = 0xFF00 (HALT) with write_reg_enable -> no register changes.
